sdfa_image_stream_tx: RTL and testbench
=======================================

// Module: sdfa_image_stream_tx
// PURPOSE
//  Transmit side of the SDFA input-spike-converter link. Shifts the 12-bit
//  setup word out serially (set_number/set_valid), buffers one image of
//  coded pixel words written by the host, and streams it to the converter
//  (data_out/pixel_valid) in two halves, paced by the converter's image_req.
// PARAMETERS
//  DATA_W      64   width of one coded pixel word
//  IMG_WORDS   196  words per image
//  HALF_WORDS  98   words per half; a gap is forced after this many
//  CFG_BITS    12   setup word length, shifted MSB first
// PORTS
//  clk          in   1          clock, all logic on rising edge
//  rstn         in   1          asynchronous active-low reset
//  cfg_word     in   CFG_BITS   setup word, sampled with cfg_load
//  cfg_load     in   1          pulse: start serial setup transfer
//  img_wr_en    in   1          host write strobe into image buffer
//  img_wr_addr  in   AW         word address, AW=$clog2(IMG_WORDS)
//  img_wr_data  in   DATA_W     word to write
//  img_commit   in   1          pulse: buffer complete, mark full
//  image_req    in   1          converter can accept words (level)
//  set_number   out  1          serial setup bit
//  set_valid    out  1          setup bit valid
//  data_out     out  DATA_W     coded pixel word to converter
//  pixel_valid  out  1          data_out valid
//  buf_full     out  1          image held, host writes blocked
//  cfg_done     out  1          setup shifted since last reset
//  frame_done   out  1          one-cycle pulse after last word accepted
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; word counter 0; buffer contents undefined.
//  FSM states IDLE, CFG, FETCH, STREAM, GAP.
//  IDLE + cfg_load: latch cfg_word -> CFG. cfg_load outside IDLE ignored.
//  CFG: CFG_BITS cycles, set_valid=1, set_number=cfg_word[CFG_BITS-1-k] in
//   cycle k; then set_valid=0, cfg_done=1, -> IDLE. Re-load allowed from IDLE.
//  Buffer: img_wr_en writes when buf_full=0; ignored when buf_full=1.
//   Address >= IMG_WORDS ignored. img_commit sets buf_full (same-cycle write
//   lands first). img_commit while buf_full=1 ignored.
//  IDLE + buf_full + cfg_done + image_req -> FETCH (1 cycle, synchronous
//   buffer read of word 0) -> STREAM. First pixel_valid 2 cycles after the
//   image_req sample. cfg_load has priority over stream start in IDLE.
//  STREAM: pixel_valid=1, data_out=word[cnt]. Transfer = pixel_valid &
//   image_req. On transfer cnt++, next word presented next cycle (prefetch;
//   no bubbles while image_req=1). image_req=0: hold data_out and pixel_valid.
//  After transfer of word HALF_WORDS-1 -> GAP: pixel_valid=0 at least one
//   cycle; leave GAP (via FETCH-equivalent prefetch) when image_req=1.
//  After transfer of word IMG_WORDS-1: pixel_valid=0, buf_full=0,
//   frame_done=1 for one cycle, cnt=0, -> IDLE.
//  HALF_WORDS >= IMG_WORDS: no GAP. Counter width AW, no wrap inside a frame.
//  Reset mid-CFG or mid-stream: abort immediately, outputs 0, buf_full=0,
//   cfg_done=0; no frame_done.
// TESTING
//  1 cfg_load, cfg_word=12'hA5C -> set_valid 12 cycles, set_number
//    1,0,1,0,0,1,0,1,1,1,0,0; then cfg_done=1.
//  2 write word i = {32'hC0DE,i}, i=0..195, commit, image_req=1 constant ->
//    98 contiguous valid words 0..97, exactly 1 gap cycle, words 98..195,
//    frame_done pulse, buf_full=0.
//  3 image_req low 5 cycles at word 40 -> data_out holds word 40, pixel_valid
//    stays 1; resumes with 41, no word lost or duplicated.
//  4 commit before any cfg_load -> no pixel_valid until cfg done; stream then
//    starts 2 cycles after image_req seen in IDLE.
//  5 img_wr_en to addr 5 while buf_full=1 -> word 5 unchanged in stream.
//  6 rstn low at word 120 -> all outputs 0 async; after release no stream
//    until new commit and cfg_load.

Source files
------------

// File: rtl/sdfa_image_stream_tx_if.sv
// rtl/sdfa_image_stream_tx_if.sv - host/converter signal bundle for sdfa_image_stream_tx
// Purpose: groups the setup, image-buffer and stream signals of the SDFA
//   transmit link so the block and its users connect through one port.
// Ports (signals):
//   cfg_word/cfg_load                         setup word and load pulse (host -> tx)
//   img_wr_en/img_wr_addr/img_wr_data         image buffer write port (host -> tx)
//   img_commit                                buffer complete pulse (host -> tx)
//   image_req                                 converter ready level (converter -> tx)
//   set_number/set_valid                      serial setup bit stream (tx -> converter)
//   data_out/pixel_valid                      coded pixel word stream (tx -> converter)
//   buf_full/cfg_done/frame_done              status (tx -> host)
// Modports: master drives the inputs of the block, slave is the block itself.
interface sdfa_image_stream_tx_if #(
  parameter int DATA_W    = 64,
  parameter int IMG_WORDS = 196,
  parameter int CFG_BITS  = 12,
  localparam int AW       = $clog2(IMG_WORDS)
);
  logic [CFG_BITS-1:0] cfg_word;
  logic                cfg_load;
  logic                img_wr_en;
  logic [AW-1:0]       img_wr_addr;
  logic [DATA_W-1:0]   img_wr_data;
  logic                img_commit;
  logic                image_req;
  logic                set_number;
  logic                set_valid;
  logic [DATA_W-1:0]   data_out;
  logic                pixel_valid;
  logic                buf_full;
  logic                cfg_done;
  logic                frame_done;

  modport master (
    output cfg_word, cfg_load, img_wr_en, img_wr_addr, img_wr_data, img_commit, image_req,
    input  set_number, set_valid, data_out, pixel_valid, buf_full, cfg_done, frame_done
  );

  modport slave (
    input  cfg_word, cfg_load, img_wr_en, img_wr_addr, img_wr_data, img_commit, image_req,
    output set_number, set_valid, data_out, pixel_valid, buf_full, cfg_done, frame_done
  );
endinterface

// File: rtl/sdfa_image_stream_tx.sv
// rtl/sdfa_image_stream_tx.sv - SDFA input-spike-converter transmit side
// Purpose: shifts the setup word out serially, holds one image of coded
//   pixel words written by the host and streams it to the converter in two
//   halves separated by a forced gap, paced by image_req.
// Ports:
//   clk   in  clock, rising edge
//   rstn  in  asynchronous active-low reset
//   bus   sdfa_image_stream_tx_if.slave: setup, buffer write, stream and status
module sdfa_image_stream_tx #(
  parameter int DATA_W     = 64,
  parameter int IMG_WORDS  = 196,
  parameter int HALF_WORDS = 98,
  parameter int CFG_BITS   = 12,
  localparam int AW        = $clog2(IMG_WORDS),
  localparam int CW        = $clog2(CFG_BITS)
) (
  input  logic                        clk,
  input  logic                        rstn,
  sdfa_image_stream_tx_if.slave       bus
);

  localparam bit HAS_GAP = (HALF_WORDS < IMG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_FETCH,
    S_STREAM,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic                cfg_done_q, cfg_done_d;
  logic                buf_full_q, buf_full_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   data_q;
  logic                load_data;
  logic [AW-1:0]       rd_addr;
  logic                wr_ok;

  logic [DATA_W-1:0]   mem [IMG_WORDS];

  // Host writes only land while the buffer is open and the address is in range.
  assign wr_ok = bus.img_wr_en && !buf_full_q &&
                 ({1'b0, bus.img_wr_addr} < (AW+1)'(IMG_WORDS));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[bus.img_wr_addr] <= bus.img_wr_data;
    end
  end

  // Output word register: loaded by the prefetch read, otherwise holds so a
  // stalled word stays on data_out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else if (load_data) begin
      data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      cfg_done_q   <= 1'b0;
      buf_full_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sr_q         <= sr_d;
      cfg_done_q   <= cfg_done_d;
      buf_full_q   <= buf_full_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sr_d         = sr_q;
    cfg_done_d   = cfg_done_q;
    buf_full_d   = buf_full_q;
    frame_done_d = 1'b0;
    load_data    = 1'b0;
    rd_addr      = cnt_q;

    if (bus.img_commit && !buf_full_q) begin
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // Setup load wins over starting a stream.
        if (bus.cfg_load) begin
          sr_d    = bus.cfg_word;
          bit_d   = '0;
          state_d = S_CFG;
        end else if (buf_full_q && cfg_done_q && bus.image_req) begin
          state_d = S_FETCH;
        end
      end
      S_CFG: begin
        sr_d  = {sr_q[CFG_BITS-2:0], 1'b0};
        bit_d = bit_q + CW'(1);
        if (bit_q == CW'(CFG_BITS-1)) begin
          cfg_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_FETCH: begin
        load_data = 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (bus.image_req) begin
          if (cnt_q == AW'(IMG_WORDS-1)) begin
            cnt_d        = '0;
            buf_full_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else if (HAS_GAP && (cnt_q == AW'(HALF_WORDS-1))) begin
            cnt_d   = cnt_q + AW'(1);
            state_d = S_GAP;
          end else begin
            // Prefetch the next word so back-to-back transfers have no bubble.
            cnt_d     = cnt_q + AW'(1);
            rd_addr   = cnt_q + AW'(1);
            load_data = 1'b1;
          end
        end
      end
      S_GAP: begin
        // The gap cycle doubles as the fetch of the first second-half word.
        if (bus.image_req) begin
          load_data = 1'b1;
          state_d   = S_STREAM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.set_valid   = (state_q == S_CFG);
  assign bus.set_number  = (state_q == S_CFG) && sr_q[CFG_BITS-1];
  assign bus.pixel_valid = (state_q == S_STREAM);
  assign bus.data_out    = data_q;
  assign bus.buf_full    = buf_full_q;
  assign bus.cfg_done    = cfg_done_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_sdfa_image_stream_tx.sv
// tb/tb_sdfa_image_stream_tx.sv - scoreboard bench for sdfa_image_stream_tx
module tb_sdfa_image_stream_tx;
  localparam int DATA_W     = 64;
  localparam int IMG_WORDS  = 196;
  localparam int HALF_WORDS = 98;
  localparam int CFG_BITS   = 12;
  localparam int AW         = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sdfa_image_stream_tx_if #(.DATA_W(DATA_W), .IMG_WORDS(IMG_WORDS), .CFG_BITS(CFG_BITS)) bus ();

  sdfa_image_stream_tx #(
    .DATA_W(DATA_W), .IMG_WORDS(IMG_WORDS), .HALF_WORDS(HALF_WORDS), .CFG_BITS(CFG_BITS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  bit                cfg_q[$];
  bit                cfg_exp_bits[12] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0};

  int  cyc = 0;
  int  frame_idx = 0;
  int  gap_len = 0;
  int  pv_cycles = 0;
  int  cfg_bits_seen = 0;
  int  frames_done = 0;
  int  cfg_done_cyc = -1;
  int  first_pv_cyc = -1;
  bit  prev_stall = 1'b0;
  bit  prev_cfg_done = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic report_missing(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=none required=event", name);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks pacing.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      frame_idx     = 0;
      gap_len       = 0;
      prev_stall    = 1'b0;
      prev_cfg_done = 1'b0;
    end else begin
      if (bus.set_valid) begin
        cfg_bits_seen++;
        if (cfg_q.size() == 0) report_missing("cfg_bit_unexpected");
        else check("cfg_bit", bus.set_number, cfg_q.pop_front());
      end
      if (bus.cfg_done && !prev_cfg_done) cfg_done_cyc = cyc;
      prev_cfg_done = bus.cfg_done;

      if (prev_stall) begin
        check("stall_valid_held", bus.pixel_valid, 1);
        check("stall_data_held", bus.data_out, prev_data);
      end

      if (bus.pixel_valid) begin
        pv_cycles++;
        if (first_pv_cyc < 0) first_pv_cyc = cyc;
        if (bus.image_req) begin
          if (frame_idx > 0) check("gap_len", gap_len, (frame_idx == HALF_WORDS) ? 1 : 0);
          if (exp_q.size() == 0) report_missing("word_unexpected");
          else check("word", bus.data_out, exp_q.pop_front());
          frame_idx++;
          gap_len = 0;
        end
      end else if (frame_idx > 0 && frame_idx < IMG_WORDS) begin
        gap_len++;
      end
      prev_stall = bus.pixel_valid && !bus.image_req;
      prev_data  = bus.data_out;

      if (bus.frame_done) begin
        frames_done++;
        check("frame_len", frame_idx, IMG_WORDS);
        check("buf_full_after_frame", bus.buf_full, 0);
        check("frame_queue_empty", exp_q.size(), 0);
        frame_idx = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_image(input logic [31:0] tag);
    for (int i = 0; i < IMG_WORDS; i++) begin
      bus.img_wr_en   = 1'b1;
      bus.img_wr_addr = AW'(i);
      bus.img_wr_data = {tag, 32'(i)};
      tick(1);
    end
    bus.img_wr_en = 1'b0;
  endtask

  task automatic commit_image(input logic [31:0] tag);
    bus.img_commit = 1'b1;
    tick(1);
    bus.img_commit = 1'b0;
    for (int i = 0; i < IMG_WORDS; i++) exp_q.push_back({tag, 32'(i)});
  endtask

  task automatic load_cfg();
    for (int k = 0; k < CFG_BITS; k++) cfg_q.push_back(cfg_exp_bits[k]);
    bus.cfg_word = 12'hA5C;
    bus.cfg_load = 1'b1;
    tick(1);
    bus.cfg_load = 1'b0;
  endtask

  task automatic wait_idx(input int n);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (frame_idx >= n) break;
    end
    #1;
    if (t >= 3000) report_missing("timeout_word_index");
  endtask

  task automatic wait_frames(input int n);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (frames_done >= n) break;
    end
    #1;
    if (t >= 3000) report_missing("timeout_frame_done");
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pixel_valid"}, bus.pixel_valid, 0);
    check({tag, "_data_out"}, bus.data_out, 0);
    check({tag, "_buf_full"}, bus.buf_full, 0);
    check({tag, "_cfg_done"}, bus.cfg_done, 0);
    check({tag, "_set_valid"}, bus.set_valid, 0);
    check({tag, "_set_number"}, bus.set_number, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_word    = '0;
    bus.cfg_load    = 1'b0;
    bus.img_wr_en   = 1'b0;
    bus.img_wr_addr = '0;
    bus.img_wr_data = '0;
    bus.img_commit  = 1'b0;
    bus.image_req   = 1'b0;
    rstn = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    rstn = 1'b1;
    tick(2);

    // Frame 1: committed before setup, so nothing streams until setup ends.
    write_image(32'h0000C0DE);
    commit_image(32'h0000C0DE);
    check("buf_full_after_commit", bus.buf_full, 1);
    bus.image_req = 1'b1;
    tick(20);
    check("no_stream_before_cfg", pv_cycles, 0);
    check("cfg_done_before_cfg", bus.cfg_done, 0);
    first_pv_cyc  = -1;
    cfg_bits_seen = 0;
    load_cfg();
    wait_frames(1);
    check("cfg_bits_seen", cfg_bits_seen, CFG_BITS);
    check("cfg_done_after_cfg", bus.cfg_done, 1);
    check("start_latency", first_pv_cyc - cfg_done_cyc, 2);

    // Frame 2: blocked write to word 5, then a 5-cycle stall at word 40.
    bus.image_req = 1'b0;
    tick(2);
    write_image(32'h0000BEEF);
    commit_image(32'h0000BEEF);
    bus.img_wr_en   = 1'b1;
    bus.img_wr_addr = AW'(5);
    bus.img_wr_data = 64'hDEAD_DEAD_DEAD_DEAD;
    tick(1);
    bus.img_wr_en = 1'b0;
    bus.image_req = 1'b1;
    wait_idx(40);
    bus.image_req = 1'b0;
    tick(2);
    check("stall_word40", bus.data_out, {32'h0000BEEF, 32'd40});
    check("stall_valid", bus.pixel_valid, 1);
    tick(3);
    bus.image_req = 1'b1;
    wait_frames(2);

    // Frame 3: reset lands while word 120 is on the bus.
    bus.image_req = 1'b0;
    tick(2);
    write_image(32'h0000F00D);
    commit_image(32'h0000F00D);
    bus.image_req = 1'b1;
    wait_idx(120);
    rstn = 1'b0;
    #1;
    check_outputs_zero("reset_mid_stream");
    exp_q.delete();
    tick(2);
    rstn = 1'b1;
    pv_cycles = 0;
    tick(30);
    check("no_stream_after_reset", pv_cycles, 0);
    check("frames_after_reset", frames_done, 2);

    // Frame 4: commit alone is not enough; setup must be reloaded.
    write_image(32'h0000FACE);
    commit_image(32'h0000FACE);
    tick(10);
    check("no_stream_without_cfg", pv_cycles, 0);
    first_pv_cyc  = -1;
    cfg_bits_seen = 0;
    load_cfg();
    wait_frames(3);
    check("cfg_bits_seen_2", cfg_bits_seen, CFG_BITS);
    check("start_latency_2", first_pv_cyc - cfg_done_cyc, 2);
    check("cfg_queue_drained", cfg_q.size(), 0);
    check("word_queue_drained", exp_q.size(), 0);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
